// File: rtl/nco_pkg.sv
// Shared encodings and elaboration-time helpers for the multi-channel quadrature NCO.
package nco_pkg;

    localparam logic [1:0] LD_FREQ  = 2'd0;
    localparam logic [1:0] LD_POFF  = 2'd1;
    localparam logic [1:0] LD_CHIRP = 2'd2;

    // Quadrant bit roles: bit 0 mirrors the table index, bit 1 negates the result.
    localparam int         QB_MIRROR    = 0;
    localparam int         QB_NEG       = 1;
    localparam logic [1:0] Q_COS_OFFSET = 2'd1;

    localparam real NCO_PI = 3.14159265358979323846;

    function automatic int nco_cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // round(A * sin(2*pi*(k+0.5)/2^lgtbl)); a Taylor series keeps this tool-independent.
    function automatic int nco_tbl_entry(input int k, input int lgtbl, input int ow);
        real x, term, sum;
        x    = 2.0 * NCO_PI * (real'(k) + 0.5) / real'(1 << lgtbl);
        term = x;
        sum  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return $rtoi(real'((1 << (ow - 1)) - 1) * sum + 0.5);
    endfunction

endpackage

// File: rtl/nco_qtable.sv
// Quarter-wave sine/cosine lookup: quadrant fold (S2), dual table read (S3), sign restore (S4).
module nco_qtable
    import nco_pkg::*;
#(
    parameter int LGTBL = 10,
    parameter int OW    = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic [LGTBL-1:0]     i_phase,
    output logic                 o_valid,
    output logic signed [OW-1:0] o_sin,
    output logic signed [OW-1:0] o_cos
);
    localparam int AW = LGTBL - 2;
    localparam int QN = 1 << AW;

    logic [OW-2:0] rom [QN];
    for (genvar k = 0; k < QN; k++) begin : g_rom
        localparam logic [OW-2:0] ENTRY = (OW-1)'(nco_tbl_entry(k, LGTBL, OW));
        assign rom[k] = ENTRY;
    end

    logic [1:0]    q_sin, q_cos;
    logic [AW-1:0] a;
    assign q_sin = i_phase[LGTBL-1 -: 2];
    assign q_cos = q_sin + Q_COS_OFFSET;
    assign a     = i_phase[AW-1:0];

    logic [AW-1:0]        s2_addr_s, s2_addr_c;
    logic                 s2_neg_s, s2_neg_c, s2_valid;
    logic [OW-2:0]        s3_mag_s, s3_mag_c;
    logic                 s3_neg_s, s3_neg_c, s3_valid;
    logic signed [OW-1:0] mag_s, mag_c;

    assign mag_s = signed'({1'b0, s3_mag_s});
    assign mag_c = signed'({1'b0, s3_mag_c});

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_addr_s <= '0;
            s2_addr_c <= '0;
            s2_neg_s  <= 1'b0;
            s2_neg_c  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_mag_s  <= '0;
            s3_mag_c  <= '0;
            s3_neg_s  <= 1'b0;
            s3_neg_c  <= 1'b0;
            s3_valid  <= 1'b0;
            o_valid   <= 1'b0;
            o_sin     <= '0;
            o_cos     <= '0;
        end else begin
            s2_addr_s <= q_sin[QB_MIRROR] ? ~a : a;
            s2_addr_c <= q_cos[QB_MIRROR] ? ~a : a;
            s2_neg_s  <= q_sin[QB_NEG];
            s2_neg_c  <= q_cos[QB_NEG];
            s2_valid  <= i_valid;

            s3_mag_s  <= rom[s2_addr_s];
            s3_mag_c  <= rom[s2_addr_c];
            s3_neg_s  <= s2_neg_s;
            s3_neg_c  <= s2_neg_c;
            s3_valid  <= s2_valid;

            o_valid   <= s3_valid;
            if (s3_valid) begin
                o_sin <= s3_neg_s ? -mag_s : mag_s;
                o_cos <= s3_neg_c ? -mag_c : mag_c;
            end
        end
    end

endmodule

// File: rtl/nco_mc.sv
// Time-multiplexed multi-channel chirping quadrature NCO: register file, round-robin
// channel counter, phase/step accumulators and the phase register (S1) feeding nco_qtable.
module nco_mc
    import nco_pkg::*;
#(
    parameter  int NCH   = 4,
    parameter  int W     = 32,
    parameter  int LGTBL = 10,
    parameter  int OW    = 12,
    localparam int CW    = nco_cw(NCH)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ld,
    input  logic [1:0]           i_ld_sel,
    input  logic [CW-1:0]        i_ld_ch,
    input  logic [W-1:0]         i_ld_data,
    input  logic                 i_sync,
    input  logic                 i_ce,
    output logic                 o_valid,
    output logic [CW-1:0]        o_ch,
    output logic signed [OW-1:0] o_sin,
    output logic signed [OW-1:0] o_cos
);
    logic [W-1:0] freq  [NCH];
    logic [W-1:0] step  [NCH];
    logic [W-1:0] poff  [NCH];
    logic [W-1:0] chirp [NCH];
    logic [W-1:0] phase [NCH];
    logic [CW-1:0] cnt;

    logic [LGTBL-1:0] s1_phase;
    logic             s1_valid, s2_valid, s3_valid;
    logic [CW-1:0]    s1_ch, s2_ch, s3_ch;

    // NOTE: the register file is flops, not RAM, so clearing it in reset is intended and cheap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NCH; k++) begin
                freq[k]  <= '0;
                step[k]  <= '0;
                poff[k]  <= '0;
                chirp[k] <= '0;
                phase[k] <= '0;
            end
            cnt <= '0;
        end else begin
            // NOTE: non-blocking updates let the later register write win over the accumulator update.
            if (i_sync) begin
                for (int k = 0; k < NCH; k++) begin
                    phase[k] <= '0;
                    step[k]  <= freq[k];
                end
                cnt <= '0;
            end else if (i_ce) begin
                phase[cnt] <= phase[cnt] + step[cnt];
                step[cnt]  <= step[cnt] + chirp[cnt];
                cnt        <= (cnt == CW'(NCH - 1)) ? '0 : cnt + 1'b1;
            end
            if (i_ld) begin
                case (i_ld_sel)
                    LD_FREQ: begin
                        freq[i_ld_ch] <= i_ld_data;
                        step[i_ld_ch] <= i_ld_data;
                    end
                    LD_POFF:  poff[i_ld_ch]  <= i_ld_data;
                    LD_CHIRP: chirp[i_ld_ch] <= i_ld_data;
                    default: ;
                endcase
            end
        end
    end

    // The channel tag travels alongside nco_qtable's three internal stages.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_phase <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s1_ch    <= '0;
            s2_ch    <= '0;
            s3_ch    <= '0;
            o_ch     <= '0;
        end else begin
            s1_phase <= LGTBL'((phase[cnt] + poff[cnt]) >> (W - LGTBL));
            s1_valid <= i_ce;
            s1_ch    <= cnt;
            s2_valid <= s1_valid;
            s2_ch    <= s1_ch;
            s3_valid <= s2_valid;
            s3_ch    <= s2_ch;
            if (s3_valid) o_ch <= s3_ch;
        end
    end

    nco_qtable #(
        .LGTBL (LGTBL),
        .OW    (OW)
    ) u_qtable (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (s1_valid),
        .i_phase   (s1_phase),
        .o_valid   (o_valid),
        .o_sin     (o_sin),
        .o_cos     (o_cos)
    );

endmodule

// File: tb/tb_nco_mc.sv
// Directed bench for nco_mc: reset, latency, quadrant stepping, phase offset, chirp/sync,
// same-cycle load vs. service, and mid-stream reset.
module tb_nco_mc;
    logic               clk = 1'b0;
    logic               i_reset_n = 1'b0;
    logic               i_ld = 1'b0;
    logic [1:0]         i_ld_sel = 2'd0;
    logic [1:0]         i_ld_ch = 2'd0;
    logic [31:0]        i_ld_data = '0;
    logic               i_sync = 1'b0;
    logic               i_ce = 1'b0;
    logic               o_valid;
    logic [1:0]         o_ch;
    logic signed [11:0] o_sin, o_cos;

    int checks = 0;
    int errors = 0;

    logic [1:0]         q_ch  [$];
    logic signed [11:0] q_sin [$];
    logic signed [11:0] q_cos [$];

    nco_mc #(.NCH(4), .W(32), .LGTBL(10), .OW(12)) dut (
        .i_clk     (clk),
        .i_reset_n (i_reset_n),
        .i_ld      (i_ld),
        .i_ld_sel  (i_ld_sel),
        .i_ld_ch   (i_ld_ch),
        .i_ld_data (i_ld_data),
        .i_sync    (i_sync),
        .i_ce      (i_ce),
        .o_valid   (o_valid),
        .o_ch      (o_ch),
        .o_sin     (o_sin),
        .o_cos     (o_cos)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            q_ch.push_back(o_ch);
            q_sin.push_back(o_sin);
            q_cos.push_back(o_cos);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        i_ce = 1'b0;
        i_ld = 1'b0;
        i_sync = 1'b0;
        repeat (2) tick();
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic ld(input logic [1:0] sel, input logic [1:0] ch, input logic [31:0] data);
        i_ld = 1'b1;
        i_ld_sel = sel;
        i_ld_ch = ch;
        i_ld_data = data;
        tick();
        i_ld = 1'b0;
    endtask

    task automatic clear_q();
        q_ch.delete();
        q_sin.delete();
        q_cos.delete();
    endtask

    task automatic run_ce(input int n);
        i_ce = 1'b1;
        repeat (n) tick();
        i_ce = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_sample(input string tag, input int idx, input int ch, input int s, input int c);
        check({tag, "_ch"}, q_ch[idx], ch);
        check({tag, "_sin"}, q_sin[idx], s);
        check({tag, "_cos"}, q_cos[idx], c);
    endtask

    initial begin
        // Reset state and pipeline latency with default registers.
        do_reset();
        check("rst_valid", o_valid, 0);
        check("rst_ch", o_ch, 0);
        check("rst_sin", o_sin, 0);
        check("rst_cos", o_cos, 0);
        clear_q();
        i_ce = 1'b1;
        repeat (3) tick();
        check("lat_pre_valid", o_valid, 0);
        tick();
        check("lat_valid", o_valid, 1);
        check("lat_ch", o_ch, 0);
        repeat (4) tick();
        i_ce = 1'b0;
        repeat (4) tick();
        check("dflt_count", q_ch.size(), 8);
        for (int i = 0; i < 8; i++)
            check_sample($sformatf("dflt%0d", i), i, i % 4, 6, 2047);

        // ch1 at a quarter turn per visit walks the four quadrants.
        do_reset();
        ld(2'd0, 2'd1, 32'h4000_0000);
        clear_q();
        run_ce(14);
        check("quad_count", q_ch.size(), 14);
        check_sample("quad_ch0", 0, 0, 6, 2047);
        check_sample("quad_q0", 1, 1, 6, 2047);
        check_sample("quad_q1", 5, 1, 2047, -6);
        check_sample("quad_q2", 9, 1, -6, -2047);
        check_sample("quad_q3", 13, 1, -2047, 6);
        check("hold_valid", o_valid, 0);
        check("hold_sin", o_sin, -2047);
        check("hold_cos", o_cos, 6);

        // Half-turn phase offset on ch2 only.
        do_reset();
        ld(2'd1, 2'd2, 32'h8000_0000);
        clear_q();
        run_ce(8);
        check_sample("poff_a", 2, 2, -6, -2047);
        check_sample("poff_b", 6, 2, -6, -2047);
        check_sample("poff_ch1", 1, 1, 6, 2047);
        check_sample("poff_ch3", 3, 3, 6, 2047);

        // Chirp on ch0: sampled phases 0,0,1,3,6,10 x 2^20 -> table index 0,0,0,0,1,2.
        do_reset();
        ld(2'd2, 2'd0, 32'h0010_0000);
        clear_q();
        run_ce(22);
        check_sample("chirp_v3", 12, 0, 6, 2047);
        check_sample("chirp_v4", 16, 0, 19, 2047);
        check_sample("chirp_v5", 20, 0, 31, 2047);

        // Sync together with i_ce: old channel (2) still emitted, then restart from ch0.
        clear_q();
        i_sync = 1'b1;
        i_ce = 1'b1;
        tick();
        i_sync = 1'b0;
        repeat (24) tick();
        i_ce = 1'b0;
        repeat (4) tick();
        check("sync_count", q_ch.size(), 25);
        check_sample("sync_old", 0, 2, 6, 2047);
        check_sample("sync_v0", 1, 0, 6, 2047);
        check_sample("sync_v1", 5, 0, 6, 2047);
        check_sample("sync_v4", 17, 0, 19, 2047);
        check_sample("sync_v5", 21, 0, 31, 2047);

        // Load ch3 frequency in the same cycle ch3 is serviced.
        do_reset();
        ld(2'd0, 2'd3, 32'h4000_0000);
        clear_q();
        i_ce = 1'b1;
        repeat (3) tick();
        i_ld = 1'b1;
        i_ld_sel = 2'd0;
        i_ld_ch = 2'd3;
        i_ld_data = 32'h8000_0000;
        tick();
        i_ld = 1'b0;
        repeat (8) tick();
        i_ce = 1'b0;
        repeat (4) tick();
        check_sample("ldce_v0", 3, 3, 6, 2047);
        check_sample("ldce_v1", 7, 3, 2047, -6);
        check_sample("ldce_v2", 11, 3, -2047, 6);

        // Reset with the pipeline full, then restart from a cleared state.
        do_reset();
        ld(2'd0, 2'd1, 32'h4000_0000);
        i_ce = 1'b1;
        repeat (6) tick();
        check("pre_rst_valid", o_valid, 1);
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_sin", o_sin, 0);
        check("mid_rst_cos", o_cos, 0);
        check("mid_rst_ch", o_ch, 0);
        i_ce = 1'b0;
        tick();
        i_reset_n = 1'b1;
        repeat (4) tick();
        check("post_rst_idle", o_valid, 0);
        clear_q();
        i_ce = 1'b1;
        repeat (3) tick();
        check("post_rst_pre", o_valid, 0);
        tick();
        check("post_rst_valid", o_valid, 1);
        repeat (4) tick();
        i_ce = 1'b0;
        repeat (4) tick();
        check("post_rst_count", q_ch.size(), 8);
        check_sample("post_rst_v0", 1, 1, 6, 2047);
        check_sample("post_rst_v1", 5, 1, 6, 2047);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
